// File: rtl/dlx_mem_pkg.sv
// -----------------------------------------------------------------------------
// dlx_mem_pkg
//
// Definitions shared by the DLX memory responder and its boot loader:
//   - WORD_W       : data word width of both arrays and the loader stream
//   - HDR_TGT_BIT  : header bit selecting the target array
//   - HDR_CNT_MSB  : MSB of the header word-count field (count is [15:0])
//   - TGT_IMEM / TGT_DMEM : encodings of the target bit
//   - ld_state_t   : boot-loader state encoding
//   - max_int()    : helper for sizing the shared loader write index
// -----------------------------------------------------------------------------
package dlx_mem_pkg;

    localparam int WORD_W = 32;

    localparam int HDR_TGT_BIT = 31;
    localparam int HDR_CNT_MSB = 15;

    localparam logic TGT_IMEM = 1'b0;
    localparam logic TGT_DMEM = 1'b1;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        DATA = 2'd1,
        RUN  = 2'd2
    } ld_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dlx_mem_loader.sv
// -----------------------------------------------------------------------------
// dlx_mem_loader
//
// Boot-loader state machine for the DLX memory responder. It consumes a
// valid/ready word stream made of blocks: one header word (target bit and
// word count N), followed by N data words written from index 0 upwards. A
// header with N=0 ends loading and releases the core.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   asynchronous, active-high
//   ld_valid   in   loader word valid
//   ld_data    in   loader word (header or data)
//   ld_ready   out  loader word accepted when ld_valid && ld_ready
//   cpu_reset  out  registered reset to the core, high until RUN
//   load_done  out  registered, high in RUN
//   imem_we    out  write strobe for the instruction array
//   dmem_we    out  write strobe for the data array
//   wr_idx     out  write index shared by both arrays; each array uses only
//                   its own low bits, so the index wraps modulo its depth
// -----------------------------------------------------------------------------
module dlx_mem_loader
    import dlx_mem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ld_valid,
    input  logic [WORD_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              imem_we,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] wr_idx
);

    ld_state_t             state_reg, state_next;
    logic [HDR_CNT_MSB:0]  cnt_reg, cnt_next;
    logic [ADDR_W-1:0]     waddr_reg, waddr_next;
    logic                  tgt_reg, tgt_next;
    logic                  ld_ready_reg;
    logic                  cpu_reset_reg;
    logic                  load_done_reg;
    logic                  handshake;

    // Header bits between the target bit and the count field carry no meaning.
    logic unused_hdr_bits;
    assign unused_hdr_bits = &{1'b0, ld_data[HDR_TGT_BIT-1:HDR_CNT_MSB+1]};

    assign handshake = ld_valid && ld_ready_reg;

    // Next-state, counter, write-address and write-strobe logic.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        waddr_next = waddr_reg;
        tgt_next   = tgt_reg;
        imem_we    = 1'b0;
        dmem_we    = 1'b0;

        case (state_reg)
            HDR: begin
                if (handshake) begin
                    tgt_next = ld_data[HDR_TGT_BIT];
                    if (ld_data[HDR_CNT_MSB:0] == '0) begin
                        state_next = RUN;
                    end else begin
                        cnt_next   = ld_data[HDR_CNT_MSB:0];
                        waddr_next = '0;
                        state_next = DATA;
                    end
                end
            end

            DATA: begin
                if (handshake) begin
                    imem_we    = (tgt_reg == TGT_IMEM);
                    dmem_we    = (tgt_reg == TGT_DMEM);
                    waddr_next = waddr_reg + 1'b1;
                    cnt_next   = cnt_reg - 1'b1;
                    if (cnt_reg == 16'd1) begin
                        state_next = HDR;
                    end
                end
            end

            RUN: begin
                // Terminal until reset; the stream is ignored.
            end

            default: begin
                state_next = HDR;
            end
        endcase
    end

    // ld_ready, cpu_reset and load_done are registered from the next state so
    // they change on the same edge as the state and never glitch. Because the
    // reset value of ld_ready is 0, ready first rises on the edge after reset
    // deasserts, and it falls on the edge that accepts the N=0 header.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= HDR;
            cnt_reg       <= '0;
            waddr_reg     <= '0;
            tgt_reg       <= TGT_IMEM;
            ld_ready_reg  <= 1'b0;
            cpu_reset_reg <= 1'b1;
            load_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            waddr_reg     <= waddr_next;
            tgt_reg       <= tgt_next;
            ld_ready_reg  <= (state_next != RUN);
            cpu_reset_reg <= (state_next != RUN);
            load_done_reg <= (state_next == RUN);
        end
    end

    assign ld_ready  = ld_ready_reg;
    assign cpu_reset = cpu_reset_reg;
    assign load_done = load_done_reg;
    assign wr_idx    = waddr_reg;

endmodule

// File: rtl/dlx_mem_responder.sv
// -----------------------------------------------------------------------------
// dlx_mem_responder
//
// Memory-side responder for the DLX five-stage pipeline. Holds separate
// instruction and data arrays, both filled by the boot loader after reset.
// Once the loader reaches RUN the core is released and gets combinational
// (zero-latency) reads on both ports plus one-edge stores on the data port.
// Outside RUN both read ports return 0 and core stores are ignored. The
// arrays have no reset, so contents survive a reset.
//
// Optional feature macro: DLX_MEM_MISALIGN_TRAP_EN
//   defined     : stores with cpu_mem_addr[1:0] != 0 are suppressed and set
//                 the sticky mis_err flag (cleared only by reset)
//   not defined : the low address bits are ignored; mis_err is tied to 0
//
// Parameters:
//   IMEM_WORDS  instruction array depth in 32-bit words (power of two, >= 2)
//   DMEM_WORDS  data array depth in 32-bit words (power of two, >= 2)
//
// Ports:
//   clock           in   system clock, rising edge
//   reset           in   asynchronous, active-high
//   cpu_reset       out  reset to the core, high until RUN
//   cpu_pc          in   fetch byte address
//   cpu_inst        out  instruction word at cpu_pc
//   cpu_mem_addr    in   data byte address
//   cpu_memdata_wr  in   store data
//   cpu_mem_wr_en   in   store strobe
//   cpu_memdata_rd  out  load data at cpu_mem_addr
//   ld_valid        in   loader word valid
//   ld_ready        out  loader word accepted when ld_valid && ld_ready
//   ld_data         in   loader word
//   load_done       out  high in RUN
//   mis_err         out  sticky misaligned-store flag
// -----------------------------------------------------------------------------
module dlx_mem_responder
    import dlx_mem_pkg::*;
#(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256
) (
    input  logic              clock,
    input  logic              reset,
    output logic              cpu_reset,
    input  logic [WORD_W-1:0] cpu_pc,
    output logic [WORD_W-1:0] cpu_inst,
    input  logic [WORD_W-1:0] cpu_mem_addr,
    input  logic [WORD_W-1:0] cpu_memdata_wr,
    input  logic              cpu_mem_wr_en,
    output logic [WORD_W-1:0] cpu_memdata_rd,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [WORD_W-1:0] ld_data,
    output logic              load_done,
    output logic              mis_err
);

    localparam int IMEM_AW = $clog2(IMEM_WORDS);
    localparam int DMEM_AW = $clog2(DMEM_WORDS);
    localparam int LD_AW   = max_int(IMEM_AW, DMEM_AW);

    logic                run;
    logic                imem_ld_we;
    logic                dmem_ld_we;
    logic [LD_AW-1:0]    wr_idx;
    logic [IMEM_AW-1:0]  imem_wr_idx;
    logic [DMEM_AW-1:0]  dmem_wr_idx;
    logic [IMEM_AW-1:0]  pc_idx;
    logic [DMEM_AW-1:0]  data_idx;
    logic                store_ok;

    logic [WORD_W-1:0]   imem_mem [IMEM_WORDS];
    logic [WORD_W-1:0]   dmem_mem [DMEM_WORDS];

    // Upper address bits alias by design, and each array only needs the low
    // bits of the shared loader index.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, cpu_pc, cpu_mem_addr, wr_idx};

    dlx_mem_loader #(
        .ADDR_W (LD_AW)
    ) u_loader (
        .clock     (clock),
        .reset     (reset),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .cpu_reset (cpu_reset),
        .load_done (load_done),
        .imem_we   (imem_ld_we),
        .dmem_we   (dmem_ld_we),
        .wr_idx    (wr_idx)
    );

    // load_done is high exactly while the loader is in RUN.
    assign run = load_done;

    assign imem_wr_idx = wr_idx[IMEM_AW-1:0];
    assign dmem_wr_idx = wr_idx[DMEM_AW-1:0];
    assign pc_idx      = cpu_pc[IMEM_AW+1:2];
    assign data_idx    = cpu_mem_addr[DMEM_AW+1:2];

`ifdef DLX_MEM_MISALIGN_TRAP_EN
    logic mis_err_reg;

    assign store_ok = run && cpu_mem_wr_en && (cpu_mem_addr[1:0] == 2'b00);

    // Sticky until reset; misaligned loads never touch it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mis_err_reg <= 1'b0;
        end else if (run && cpu_mem_wr_en && (cpu_mem_addr[1:0] != 2'b00)) begin
            mis_err_reg <= 1'b1;
        end
    end

    assign mis_err = mis_err_reg;
`else
    assign store_ok = run && cpu_mem_wr_en;
    assign mis_err  = 1'b0;
`endif

    // Instruction array: written only by the loader.
    always_ff @(posedge clock) begin
        if (imem_ld_we) begin
            imem_mem[imem_wr_idx] <= ld_data;
        end
    end

    // Data array: loader writes happen only before RUN and core stores only
    // in RUN, so the two write sources never collide.
    always_ff @(posedge clock) begin
        if (dmem_ld_we) begin
            dmem_mem[dmem_wr_idx] <= ld_data;
        end else if (store_ok) begin
            dmem_mem[data_idx] <= cpu_memdata_wr;
        end
    end

    // Combinational reads so the core can register the data in its own stage.
    always_comb begin
        cpu_inst       = '0;
        cpu_memdata_rd = '0;
        if (run) begin
            cpu_inst       = imem_mem[pc_idx];
            cpu_memdata_rd = dmem_mem[data_idx];
        end
    end

endmodule

// File: tb/tb_dlx_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_dlx_mem_responder
//
// Self-checking bench for dlx_mem_responder (IMEM_WORDS=4, DMEM_WORDS=256).
// A reference model keeps plain arrays of the expected memory contents,
// indexed modulo the array depth, plus a known-flag per word since the
// arrays have no reset value. Honours DLX_MEM_MISALIGN_TRAP_EN.
// -----------------------------------------------------------------------------
module tb_dlx_mem_responder;

    localparam int IMEM_WORDS = 4;
    localparam int DMEM_WORDS = 256;

`ifdef DLX_MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_reset;
    logic [31:0] cpu_pc = '0;
    logic [31:0] cpu_inst;
    logic [31:0] cpu_mem_addr = '0;
    logic [31:0] cpu_memdata_wr = '0;
    logic        cpu_mem_wr_en = 1'b0;
    logic [31:0] cpu_memdata_rd;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [31:0] ld_data = '0;
    logic        load_done;
    logic        mis_err;

    int checks = 0;
    int errors = 0;

    // Reference model
    logic [31:0] imem_m [IMEM_WORDS];
    bit          imem_k [IMEM_WORDS];
    logic [31:0] dmem_m [DMEM_WORDS];
    bit          dmem_k [DMEM_WORDS];
    bit          mis_m;

    logic [31:0] word_q [$];

    // Basic-load payload, reused by the back-pressure run.
    logic [31:0] word_a, word_b, word_c, word_d, word_e;

    dlx_mem_responder #(
        .IMEM_WORDS (IMEM_WORDS),
        .DMEM_WORDS (DMEM_WORDS)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .cpu_reset      (cpu_reset),
        .cpu_pc         (cpu_pc),
        .cpu_inst       (cpu_inst),
        .cpu_mem_addr   (cpu_mem_addr),
        .cpu_memdata_wr (cpu_memdata_wr),
        .cpu_mem_wr_en  (cpu_mem_wr_en),
        .cpu_memdata_rd (cpu_memdata_rd),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_data        (ld_data),
        .load_done      (load_done),
        .mis_err        (mis_err)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one word and wait (bounded) until it is accepted.
    task automatic send_word(input logic [31:0] w, input bit gaps);
        int  wait_cnt;
        bit  rdy;
        wait_cnt = 0;
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                ld_valid = 1'b0;
                ld_data  = $urandom;
                tick();
            end
        end
        ld_valid = 1'b1;
        ld_data  = w;
        forever begin
            rdy = ld_ready;
            tick();
            if (rdy) break;
            wait_cnt++;
            if (wait_cnt > 20) begin
                checks++;
                errors++;
                $display("FAIL handshake_timeout: word %h not accepted, ld_ready=%b required 1", w, ld_ready);
                break;
            end
        end
    endtask

    // Header followed by its N words from word_q; updates the model.
    task automatic send_block(input logic [31:0] hdr, input bit gaps);
        int n;
        n = int'(hdr[15:0]);
        send_word(hdr, gaps);
        for (int i = 0; i < n; i++) begin
            send_word(word_q[i], gaps);
            if (hdr[31]) begin
                dmem_m[i % DMEM_WORDS] = word_q[i];
                dmem_k[i % DMEM_WORDS] = 1'b1;
            end else begin
                imem_m[i % IMEM_WORDS] = word_q[i];
                imem_k[i % IMEM_WORDS] = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        ld_valid      = 1'b0;
        cpu_mem_wr_en = 1'b0;
        reset         = 1'b1;
        mis_m         = 1'b0;
        #1;
        if (cpu_reset !== 1'b1) begin errors++; $display("FAIL reset_cpu_reset: got %b required 1", cpu_reset); end
        if (ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready: got %b required 0", ld_ready); end
        if (load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done: got %b required 0", load_done); end
        if (mis_err !== 1'b0) begin errors++; $display("FAIL reset_mis_err: got %b required 0", mis_err); end
        if (cpu_inst !== 32'h0) begin errors++; $display("FAIL reset_cpu_inst: got %h required 0", cpu_inst); end
        if (cpu_memdata_rd !== 32'h0) begin errors++; $display("FAIL reset_memdata_rd: got %h required 0", cpu_memdata_rd); end
        checks += 6;
        repeat (2) tick();
        if (ld_ready !== 1'b0) begin errors++; $display("FAIL reset_held_ld_ready: got %b required 0", ld_ready); end
        if (cpu_reset !== 1'b1) begin errors++; $display("FAIL reset_held_cpu_reset: got %b required 1", cpu_reset); end
        checks += 2;
        reset = 1'b0;
        #1;
        if (ld_ready !== 1'b0) begin errors++; $display("FAIL release_ld_ready_early: got %b required 0", ld_ready); end
        checks++;
        tick();
        if (ld_ready !== 1'b1) begin errors++; $display("FAIL release_ld_ready: got %b required 1", ld_ready); end
        if (cpu_reset !== 1'b1) begin errors++; $display("FAIL release_cpu_reset: got %b required 1", cpu_reset); end
        checks += 2;
        $display("reset: ld_ready=%b cpu_reset=%b load_done=%b", ld_ready, cpu_reset, load_done);
    endtask

    task automatic test_basic_load(input bit gaps);
        word_q = '{word_a, word_b, word_c};
        send_block(32'h0000_0003, gaps);
        word_q = '{word_d, word_e};
        send_block(32'h8000_0002, gaps);
        if (cpu_reset !== 1'b1) begin errors++; $display("FAIL load_cpu_reset_before_end: got %b required 1", cpu_reset); end
        checks++;
        word_q = {};
        send_block(32'h0000_0000, gaps);
        if (cpu_reset !== 1'b0) begin errors++; $display("FAIL load_cpu_reset_release: got %b required 0", cpu_reset); end
        if (load_done !== 1'b1) begin errors++; $display("FAIL load_done: got %b required 1", load_done); end
        if (ld_ready !== 1'b0) begin errors++; $display("FAIL load_ld_ready_run: got %b required 0", ld_ready); end
        checks += 3;
        // Keep valid high with a would-be header; it must not be consumed.
        ld_valid = 1'b1;
        ld_data  = 32'h0000_0001;
        repeat (3) begin
            tick();
            if (ld_ready !== 1'b0 || load_done !== 1'b1) begin
                errors++;
                $display("FAIL run_ignores_valid: ld_ready=%b load_done=%b required 0/1", ld_ready, load_done);
            end
            checks++;
        end
        ld_valid = 1'b0;
        cpu_pc       = 32'h0000_0008;
        cpu_mem_addr = 32'h0000_0004;
        #1;
        if (cpu_inst !== word_c) begin errors++; $display("FAIL basic_inst_pc8: got %h required %h", cpu_inst, word_c); end
        if (cpu_memdata_rd !== word_e) begin errors++; $display("FAIL basic_data_addr4: got %h required %h", cpu_memdata_rd, word_e); end
        checks += 2;
        $display("basic_load gaps=%0d: inst[8]=%h data[4]=%h", gaps, cpu_inst, cpu_memdata_rd);
    endtask

    // Sweep every known word of both arrays through aliased, misaligned addresses.
    task automatic test_readback();
        cpu_mem_wr_en = 1'b0;
        for (int i = 0; i < IMEM_WORDS; i++) begin
            if (imem_k[i]) begin
                cpu_pc = ($urandom << 4) | (i << 2) | $urandom_range(0, 3);
                #1;
                if (cpu_inst !== imem_m[i]) begin
                    errors++;
                    $display("FAIL readback_imem[%0d]: pc=%h got %h required %h", i, cpu_pc, cpu_inst, imem_m[i]);
                end
                checks++;
            end
        end
        for (int i = 0; i < DMEM_WORDS; i += 7) begin
            if (dmem_k[i]) begin
                cpu_mem_addr = ($urandom << 10) | (i << 2) | $urandom_range(0, 3);
                #1;
                if (cpu_memdata_rd !== dmem_m[i]) begin
                    errors++;
                    $display("FAIL readback_dmem[%0d]: addr=%h got %h required %h", i, cpu_mem_addr, cpu_memdata_rd, dmem_m[i]);
                end
                checks++;
            end
        end
        $display("readback: swept imem and dmem, errors so far %0d", errors);
    endtask

    task automatic test_store_then_load();
        logic [31:0] first;
        first = $urandom;
        cpu_mem_addr   = 32'h0000_0010;
        cpu_memdata_wr = first;
        cpu_mem_wr_en  = 1'b1;
        tick();
        cpu_memdata_wr = 32'hDEAD_BEEF;
        #1;
        if (cpu_memdata_rd !== first) begin errors++; $display("FAIL store_same_cycle_old: got %h required %h", cpu_memdata_rd, first); end
        checks++;
        tick();
        cpu_mem_wr_en = 1'b0;
        #1;
        if (cpu_memdata_rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_next_cycle: got %h required deadbeef", cpu_memdata_rd); end
        cpu_mem_addr = 32'h0000_0410;
        #1;
        if (cpu_memdata_rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_alias_410: got %h required deadbeef", cpu_memdata_rd); end
        checks += 2;
        dmem_m[4] = 32'hDEAD_BEEF;
        dmem_k[4] = 1'b1;
        $display("store_then_load: addr 0x10/0x410 -> %h", cpu_memdata_rd);
    endtask

    task automatic test_random_access();
        logic [31:0] addr;
        int          idx;
        bit          we;
        for (int n = 0; n < 60; n++) begin
            addr = {$urandom_range(0, 15), 20'h0, 8'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 3) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            idx = int'(addr[9:2]);
            we  = ($urandom_range(0, 1) == 1);
            cpu_mem_addr   = addr;
            cpu_memdata_wr = $urandom;
            cpu_mem_wr_en  = we;
            cpu_pc         = $urandom;
            #1;
            if (dmem_k[idx]) begin
                if (cpu_memdata_rd !== dmem_m[idx]) begin
                    errors++;
                    $display("FAIL rand_load: addr=%h got %h required %h", addr, cpu_memdata_rd, dmem_m[idx]);
                end
                checks++;
            end
            if (imem_k[cpu_pc[3:2]]) begin
                if (cpu_inst !== imem_m[cpu_pc[3:2]]) begin
                    errors++;
                    $display("FAIL rand_fetch: pc=%h got %h required %h", cpu_pc, cpu_inst, imem_m[cpu_pc[3:2]]);
                end
                checks++;
            end
            if (mis_err !== mis_m) begin
                errors++;
                $display("FAIL rand_mis_err: got %b required %b", mis_err, mis_m);
            end
            checks++;
            tick();
            if (we) begin
                if (TRAP && addr[1:0] != 2'b00) begin
                    mis_m = 1'b1;
                end else begin
                    dmem_m[idx] = cpu_memdata_wr;
                    dmem_k[idx] = 1'b1;
                end
            end
        end
        cpu_mem_wr_en = 1'b0;
        $display("random_access: 60 cycles, mis_err=%b", mis_err);
    endtask

    task automatic test_misaligned();
        logic [31:0] old_val;
        logic [31:0] exp_val;
        old_val        = dmem_m[4];
        exp_val        = TRAP ? old_val : 32'h1234_5678;
        cpu_mem_addr   = 32'h0000_0013;
        cpu_memdata_wr = 32'h1234_5678;
        cpu_mem_wr_en  = 1'b1;
        tick();
        cpu_mem_wr_en = 1'b0;
        cpu_mem_addr  = 32'h0000_0010;
        #1;
        if (cpu_memdata_rd !== exp_val) begin errors++; $display("FAIL misaligned_store_data: got %h required %h", cpu_memdata_rd, exp_val); end
        if (mis_err !== TRAP) begin errors++; $display("FAIL misaligned_mis_err: got %b required %b", mis_err, TRAP); end
        checks += 2;
        cpu_mem_addr = 32'h0000_0011;
        repeat (3) tick();
        if (cpu_memdata_rd !== exp_val) begin errors++; $display("FAIL misaligned_load: got %h required %h", cpu_memdata_rd, exp_val); end
        if (mis_err !== TRAP) begin errors++; $display("FAIL misaligned_sticky: got %b required %b", mis_err, TRAP); end
        checks += 2;
        dmem_m[4] = exp_val;
        if (TRAP) mis_m = 1'b1;
        $display("misaligned: dmem[4]=%h mis_err=%b", cpu_memdata_rd, mis_err);
    endtask

    task automatic test_wrap();
        logic [31:0] wrap_exp [IMEM_WORDS];
        wrap_exp = '{32'd5, 32'd6, 32'd3, 32'd4};
        word_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
        send_block(32'h0000_0006, 1'b0);
        word_q = {};
        send_block(32'h0000_0000, 1'b0);
        ld_valid = 1'b0;
        for (int i = 0; i < IMEM_WORDS; i++) begin
            cpu_pc = i * 4;
            #1;
            if (cpu_inst !== wrap_exp[i] || cpu_inst !== imem_m[i]) begin
                errors++;
                $display("FAIL wrap_imem[%0d]: got %h required %h", i, cpu_inst, wrap_exp[i]);
            end
            checks++;
        end
        $display("wrap: imem loaded with N=6 over depth 4");
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] p, q;
        p = $urandom;
        q = $urandom;
        // Core stores outside RUN must be dropped.
        cpu_mem_addr   = 32'h0000_0000;
        cpu_memdata_wr = 32'hBAD0_BAD0;
        cpu_mem_wr_en  = 1'b1;
        #1;
        if (cpu_memdata_rd !== 32'h0) begin errors++; $display("FAIL hdr_read_zero: got %h required 0", cpu_memdata_rd); end
        checks++;
        tick();
        cpu_mem_wr_en = 1'b0;
        send_word(32'h8000_0004, 1'b0);
        send_word(p, 1'b0);
        send_word(q, 1'b0);
        ld_valid  = 1'b0;
        dmem_m[0] = p; dmem_k[0] = 1'b1;
        dmem_m[1] = q; dmem_k[1] = 1'b1;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (cpu_reset !== 1'b1 || ld_ready !== 1'b0) begin
                errors++;
                $display("FAIL midload_reset_outputs: cpu_reset=%b ld_ready=%b required 1/0", cpu_reset, ld_ready);
            end
            checks++;
            tick();
        end
        reset = 1'b0;
        tick();
        if (ld_ready !== 1'b1) begin errors++; $display("FAIL midload_ready_after: got %b required 1", ld_ready); end
        checks++;
        // In HDR an N=0 header releases immediately; in DATA it would be stored.
        send_word(32'h0000_0000, 1'b0);
        ld_valid = 1'b0;
        if (load_done !== 1'b1) begin errors++; $display("FAIL midload_back_in_hdr: load_done=%b required 1", load_done); end
        checks++;
        cpu_mem_addr = 32'h0;
        #1;
        if (cpu_memdata_rd !== p) begin errors++; $display("FAIL midload_word0: got %h required %h", cpu_memdata_rd, p); end
        cpu_mem_addr = 32'h4;
        #1;
        if (cpu_memdata_rd !== q) begin errors++; $display("FAIL midload_word1: got %h required %h", cpu_memdata_rd, q); end
        checks += 2;
        $display("reset_mid_load: retained %h %h", p, q);
    endtask

    initial begin
        word_a = $urandom; word_b = $urandom; word_c = $urandom;
        word_d = $urandom; word_e = $urandom;
        for (int i = 0; i < IMEM_WORDS; i++) imem_k[i] = 1'b0;
        for (int i = 0; i < DMEM_WORDS; i++) dmem_k[i] = 1'b0;
        mis_m = 1'b0;
        #2;

        test_reset();
        test_basic_load(1'b0);
        test_readback();
        test_store_then_load();
        test_random_access();
        test_misaligned();
        test_readback();

        test_reset();
        test_basic_load(1'b1);
        test_readback();

        test_reset();
        test_wrap();
        test_readback();

        test_reset();
        test_reset_mid_load();
        test_readback();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
